// File: rtl/chop_generator.sv
// Chopper waveform generator: programmable period/duty, delayed copy and post-edge hold strobe.
// Optional hold logic is built only when CHOP_HOLD_EN is defined; otherwise data_hold_o is tied low.
module chop_generator #(
  parameter int unsigned DLY_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chop_en,
  input  logic        chop_default,
  input  logic [31:0] change_count,
  input  logic [31:0] max_count,
  output logic        chop_o,
  output logic        chop_dly_o,
  output logic        data_hold_o
);

  logic [31:0]           cnt_q, cnt_d;
  logic                  chop_q, chop_d;
  logic [DLY_CYCLES-1:0] dly_q, dly_d;

  // Next-state for period counter, chop level and delay pipe
  always_comb begin
    cnt_d  = cnt_q;
    chop_d = chop_q;
    dly_d  = DLY_CYCLES'({dly_q, chop_q});
    if (!chop_en) begin
      cnt_d  = 32'd0;
      chop_d = chop_default;
    end else begin
      chop_d = (cnt_q < change_count);
      // >= lets a reduced max_count wrap immediately; max_count of 0 or 1 pins the counter
      if ((max_count <= 32'd1) || (cnt_q >= (max_count - 32'd1))) begin
        cnt_d = 32'd0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // Counter, chop output and delay pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 32'd0;
      chop_q <= 1'b0;
      dly_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      chop_q <= chop_d;
      dly_q  <= dly_d;
    end
  end

  assign chop_o     = chop_q;
  assign chop_dly_o = dly_q[DLY_CYCLES-1];

`ifdef CHOP_HOLD_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       chop_prev_q;
  logic       hold_q;

  // Hold counter reloads on every chop_o edge so the strobe always spans HOLD_CYCLES from the latest edge
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (chop_q != chop_prev_q) begin
      hold_cnt_d = 8'(HOLD_CYCLES);
    end else if (hold_cnt_q != 8'd0) begin
      hold_cnt_d = hold_cnt_q - 8'd1;
    end else begin
      hold_cnt_d = 8'd0;
    end
  end

  // Edge-detect history, hold counter and registered strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chop_prev_q <= 1'b0;
      hold_cnt_q  <= 8'd0;
      hold_q      <= 1'b0;
    end else begin
      chop_prev_q <= chop_q;
      hold_cnt_q  <= hold_cnt_d;
      hold_q      <= (hold_cnt_d != 8'd0);
    end
  end

  assign data_hold_o = hold_q;
`else
  assign data_hold_o = 1'b0;
`endif

endmodule

// File: tb/tb_chop_generator.sv
// Directed bench for chop_generator: cycle model feeds a scoreboard, plus window counts of duty and hold pulses.
module tb_chop_generator;

  localparam int DLY  = 2;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chop_en = 1'b0;
  logic        chop_default = 1'b0;
  logic [31:0] change_count = 32'd0;
  logic [31:0] max_count = 32'd0;
  logic        chop_o, chop_dly_o, data_hold_o;

  chop_generator #(.DLY_CYCLES(DLY), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .chop_en(chop_en), .chop_default(chop_default),
    .change_count(change_count), .max_count(max_count),
    .chop_o(chop_o), .chop_dly_o(chop_dly_o), .data_hold_o(data_hold_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic chop; logic dly; logic hold;} exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail = 0;
  logic [32:0] m_cnt;
  logic        h [0:15];
  int win_high, win_hold, win_rise;
  logic prev_hold;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 33'd0;
    for (int i = 0; i < 16; i++) h[i] = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic win_clear();
    win_high = 0;
    win_hold = 0;
    win_rise = 0;
  endtask

  // One clock: model predicts at the rising edge, DUT compared at the falling edge
  task automatic cyc();
    exp_t e;
    logic nc, hh;
    @(posedge clk);
    nc = chop_en ? (m_cnt < {1'b0, change_count}) : chop_default;
    if (!chop_en) m_cnt = 33'd0;
    else if (m_cnt + 33'd1 >= {1'b0, max_count}) m_cnt = 33'd0;
    else m_cnt = m_cnt + 33'd1;
    for (int i = 15; i > 0; i--) h[i] = h[i-1];
    h[0] = nc;
    hh = 1'b0;
    for (int j = 1; j <= HOLD; j++) if (h[j] != h[j+1]) hh = 1'b1;
`ifndef CHOP_HOLD_EN
    hh = 1'b0;
`endif
    e.chop = h[0];
    e.dly  = h[DLY];
    e.hold = hh;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("chop_o", chop_o, e.chop);
    chk("chop_dly_o", chop_dly_o, e.dly);
    chk("data_hold_o", data_hold_o, e.hold);
    win_high += int'(chop_o);
    win_hold += int'(data_hold_o);
    if (data_hold_o && !prev_hold) win_rise++;
    prev_hold = data_hold_o;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int exp_pulses, exp_hold_cycles;
`ifdef CHOP_HOLD_EN
    exp_pulses = 2;
    exp_hold_cycles = 2 * HOLD;
`else
    exp_pulses = 0;
    exp_hold_cycles = 0;
`endif
    model_reset();
    win_clear();
    #1;
    chk("rst_chop", chop_o, 1'b0);
    chk("rst_dly", chop_dly_o, 1'b0);
    chk("rst_hold", data_hold_o, 1'b0);

    // Nominal 1000/2000 chopping from reset release
    chop_en = 1'b1;
    change_count = 32'd1000;
    max_count = 32'd2000;
    @(negedge clk);
    rst_n = 1'b1;
    run(100);
    win_clear();
    run(2000);
    chk_int("period_high_cycles", win_high, 1000);
    chk_int("period_hold_pulses", win_rise, exp_pulses);
    chk_int("period_hold_cycles", win_hold, exp_hold_cycles);
    run(50);

    // Asynchronous reset mid-run, observed between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_chop", chop_o, 1'b0);
    chk("async_rst_dly", chop_dly_o, 1'b0);
    chk("async_rst_hold", data_hold_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    chk("post_rst_2nd_edge", chop_o, 1'b1);

    // Shrink period while cnt=1200: wraps on the next edge into a 250/500 waveform
    run(1198);
    max_count = 32'd500;
    change_count = 32'd250;
    run(10);
    win_clear();
    run(500);
    chk_int("short_period_high", win_high, 250);
    run(300);

    // Disabled: static default level, then a single falling edge
    chop_en = 1'b0;
    chop_default = 1'b1;
    run(10);
    win_clear();
    run(20);
    chk_int("disabled_no_pulses", win_rise, 0);
    chk_int("disabled_high", win_high, 20);
    win_clear();
    chop_default = 1'b0;
    run(20);
    chk_int("default_fall_pulses", win_rise, exp_pulses / 2);
    chk("default_low", chop_o, 1'b0);

    // Boundaries on change_count and max_count
    chop_en = 1'b1;
    change_count = 32'd0;
    max_count = 32'd2000;
    run(10);
    win_clear();
    run(290);
    chk_int("cc0_high", win_high, 0);
    change_count = 32'd2500;
    run(10);
    win_clear();
    run(290);
    chk_int("cc_over_max_high", win_high, 290);
    change_count = 32'd1;
    max_count = 32'd1;
    run(10);
    win_clear();
    run(50);
    chk_int("max1_high", win_high, 50);
    max_count = 32'd0;
    run(50);
    change_count = 32'd0;
    max_count = 32'd1;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
